// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit feeding the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-fixed at the end.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0]       OP_MULT = 3'b101;
    localparam logic [2:0]       OP_DIV  = 3'b110;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_op_mult;
    logic                 w_op_div;
    logic                 w_b_zero;

    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;
    logic                 r_is_div;
    logic                 r_neg_lo;
    logic                 r_neg_hi;
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_sub;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_prod_neg;
    logic [WIDTH-1:0]     w_q_neg;
    logic [WIDTH-1:0]     w_r_neg;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    assign w_op_mult   = (alu_control == OP_MULT);
    assign w_op_div    = (alu_control == OP_DIV);
    assign w_b_zero    = (src_b == '0);
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

    // Operand magnitudes; -2^(W-1) maps to unsigned 2^(W-1) without extra bit
    always_comb begin
        w_mag_a = src_a[WIDTH-1] ? ({WIDTH{1'b0}} - src_a) : src_a;
        w_mag_b = src_b[WIDTH-1] ? ({WIDTH{1'b0}} - src_b) : src_b;
    end

    // One shift-add multiply step: {partial, multiplier} shifts right
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
        w_mul_step = {w_sum, r_acc[WIDTH-1:1]};
    end

    // One restoring divide step: {remainder, dividend/quotient} shifts left
    always_comb begin
        w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
        w_ge       = (w_rem_sh >= {1'b0, r_opb});
        w_sub      = w_rem_sh[WIDTH-1:0] - r_opb;
        w_div_step = {(w_ge ? w_sub : w_rem_sh[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_ge};
    end

    // Sign correction of the raw magnitude result
    always_comb begin
        w_prod_neg = {(2*WIDTH){1'b0}} - r_acc;
        w_q_neg    = {WIDTH{1'b0}} - r_acc[WIDTH-1:0];
        w_r_neg    = {WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            w_fix_lo = r_neg_lo ? w_q_neg : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_hi ? w_r_neg : r_acc[2*WIDTH-1:WIDTH];
        end else begin
            w_fix_lo = r_neg_lo ? w_prod_neg[WIDTH-1:0]
                                : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_lo ? w_prod_neg[2*WIDTH-1:WIDTH]
                                : r_acc[2*WIDTH-1:WIDTH];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && (w_op_mult || w_op_div)) begin
                    w_accept = 1'b1;
                    w_next   = (w_op_div && w_b_zero) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_next = S_FIX;
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and HI/LO write-back
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
            r_opb    <= w_mag_b;
            r_is_div <= w_op_div;
            r_neg_lo <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            r_neg_hi <= src_a[WIDTH-1];
            r_dbz    <= w_op_div && w_b_zero;
        end else if (r_state == S_RUN) begin
            r_acc <= r_is_div ? w_div_step : w_mul_step;
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state == S_FIX) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    localparam logic [2:0] MULT = 3'b101;
    localparam logic [2:0] DIV  = 3'b110;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  alu_control = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          acc_cyc;
        int          lat;
        int          busy_len;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          busy_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare each done pulse against the oldest expectation
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("div_by_zero", div_by_zero, e.dbz);
                    check("latency", cyc - e.acc_cyc, e.lat);
                    check("busy_cycles", busy_cnt, e.busy_len);
                end
                busy_cnt = 0;
            end
        end
    end

    // Reference result from signed 64-bit arithmetic
    task automatic model(input logic [2:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, output exp_t e);
        longint sa, sb_, p, q, r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.dbz = 1'b0;
        e.lat = 33;
        e.busy_len = 34;
        if (ctl == MULT) begin
            p = sa * sb_;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 0) begin
            e.dbz = 1'b1;
            e.lat = 0;
            e.busy_len = 1;
        end else begin
            q = sa / sb_;
            r = sa % sb_;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Issue one request; valid opcodes push an expectation
    task automatic issue(input logic [2:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input bit wait_done);
        exp_t e;
        bit   valid;
        valid = (ctl == MULT) || (ctl == DIV);
        @(negedge clk);
        start = 1'b1;
        alu_control = ctl;
        src_a = a;
        src_b = b;
        if (valid) model(ctl, a, b, e);
        @(posedge clk);
        #1;
        if (valid) begin
            e.acc_cyc = cyc;
            sb.push_back(e);
        end else begin
            check("ignored_op_busy", busy, 0);
        end
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        if (wait_done) wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 32'h0;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h8000_0000;
            3: pick = 32'h7FFF_FFFF;
            4: pick = $urandom_range(0, 20);
            5: pick = -$urandom_range(1, 20);
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset_n = 1'b1;

        issue(MULT, 32'd7, 32'hFFFF_FFFD, 1);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1);
        issue(DIV, 32'h5678_1234, 32'h0001_0000, 1);
        issue(DIV, 32'd5, 32'd0, 1);
        issue(MULT, 32'd2, 32'd3, 1);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(MULT, 32'h8000_0000, 32'h8000_0000, 1);

        // start pulsed mid-operation must be ignored
        issue(MULT, 32'd3, 32'd4, 0);
        repeat (8) @(negedge clk);
        start = 1'b1;
        alu_control = DIV;
        src_a = 32'd9;
        src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] c;
            c = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 4))
              : ($urandom_range(0, 1) ? MULT : DIV);
            issue(c, pick(), pick(), 1);
        end

        // asynchronous reset aborts an operation in flight
        issue(MULT, 32'd100, 32'd100, 0);
        repeat (14) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        issue(3'b000, 32'd1, 32'd1, 0);
        repeat (3) @(negedge clk);
        check("idle_after_bad_op", busy, 0);

        issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
